// File: rtl/lc3b_types.sv
// Shared types for the LC-3b data-memory responder: word type, FSM states
// and the latched request record.
package lc3b_types;

    typedef logic [15:0] lc3b_word;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } lc3b_dmem_state;

    localparam int LC3B_BYTES_PER_WORD = 2;
    localparam int LC3B_LATENCY_MAX    = 15;

    // Request as captured in IDLE; word is the full 15-bit word address.
    typedef struct packed {
        logic       is_read;
        logic       is_write;
        logic [1:0] mask;
        logic [14:0] word;
        lc3b_word   wdata;
    } lc3b_dmem_req;

endpackage

// File: rtl/dmem_array.sv
// Byte-lane word storage with registered read and per-byte write enables.
// Storage is cleared by reset so it lives in fabric registers, not block RAM.
module dmem_array
    import lc3b_types::*;
#(
    parameter int DEPTH_WORDS = 256
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [$clog2(DEPTH_WORDS)-1:0] rd_idx,
    output lc3b_word                       rd_data,
    input  logic                           wr_en,
    input  logic [$clog2(DEPTH_WORDS)-1:0] wr_idx,
    input  logic [1:0]                     wr_mask,
    input  lc3b_word                       wr_data
);

    genvar gi;
    generate
        for (gi = 0; gi < LC3B_BYTES_PER_WORD; gi++) begin : g_lane
            logic [7:0] lane_mem [DEPTH_WORDS];
            logic [7:0] lane_rd_reg;

            // Read-before-write: a same-edge read returns the old byte.
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    for (int i = 0; i < DEPTH_WORDS; i++) begin
                        lane_mem[i] <= 8'h00;
                    end
                    lane_rd_reg <= 8'h00;
                end else begin
                    lane_rd_reg <= lane_mem[rd_idx];
                    if (wr_en && wr_mask[gi]) begin
                        lane_mem[wr_idx] <= wr_data[gi*8 +: 8];
                    end
                end
            end

            assign rd_data[gi*8 +: 8] = lane_rd_reg;
        end
    endgenerate

endmodule

// File: rtl/dmem_responder.sv
// Fixed-latency data-memory responder: IDLE/WAIT/RESP handshake FSM,
// latency counter, completion counters and sticky protocol-error flag.
module dmem_responder
    import lc3b_types::*;
#(
    parameter int LATENCY     = 2,
    parameter int DEPTH_WORDS = 256
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        read_b,
    input  logic        write_b,
    input  logic [1:0]  wmask_b,
    input  logic [15:0] address_b,
    input  lc3b_word    wdata_b,
    output logic        resp_b,
    output lc3b_word    rdata_b,
    output logic        err,
    output logic [15:0] rd_count,
    output logic [15:0] wr_count
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam logic [3:0] WAIT_LOAD = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;

    lc3b_dmem_state state_reg;
    lc3b_dmem_req   req_reg;
    logic [3:0]     wait_cnt_reg;
    logic           resp_reg;
    logic           err_reg;
    logic [15:0]    rd_count_reg;
    logic [15:0]    wr_count_reg;

    logic [14:0]    live_word;
    logic [AW-1:0]  live_idx;
    logic [AW-1:0]  req_idx;
    logic [AW-1:0]  rd_idx;
    lc3b_word       rd_data;
    logic           wr_en;
    logic           req_active;
    logic           unused_addr_bits;

    assign live_word  = address_b[15:1];
    assign live_idx   = live_word[AW-1:0];
    assign req_idx    = req_reg.word[AW-1:0];
    assign req_active = read_b | write_b;
    assign unused_addr_bits = ^{address_b[0], live_word, req_reg.word};

    // In IDLE the live address feeds the registered read so that data is
    // ready even when LATENCY=1 jumps straight to RESP.
    assign rd_idx = (state_reg == IDLE) ? live_idx : req_idx;
    assign wr_en  = (state_reg == RESP) && req_reg.is_write;

    dmem_array #(
        .DEPTH_WORDS(DEPTH_WORDS)
    ) u_array (
        .clk     (clk),
        .rst_n   (rst_n),
        .rd_idx  (rd_idx),
        .rd_data (rd_data),
        .wr_en   (wr_en),
        .wr_idx  (req_idx),
        .wr_mask (req_reg.mask),
        .wr_data (req_reg.wdata)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            req_reg      <= '0;
            wait_cnt_reg <= 4'd0;
            resp_reg     <= 1'b0;
            err_reg      <= 1'b0;
            rd_count_reg <= 16'h0000;
            wr_count_reg <= 16'h0000;
        end else begin
            resp_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (req_active) begin
                        req_reg.is_read  <= read_b;
                        req_reg.is_write <= write_b;
                        req_reg.mask     <= wmask_b;
                        req_reg.word     <= live_word;
                        req_reg.wdata    <= wdata_b;
                        if (read_b && write_b) begin
                            err_reg <= 1'b1;
                        end
                        if (LATENCY <= 1) begin
                            state_reg <= RESP;
                            resp_reg  <= 1'b1;
                        end else begin
                            state_reg    <= WAIT;
                            wait_cnt_reg <= WAIT_LOAD;
                        end
                    end
                end
                WAIT: begin
                    // Initiator must hold the request; dropping it aborts.
                    if (!req_active) begin
                        state_reg <= IDLE;
                    end else if (wait_cnt_reg == 4'd0) begin
                        state_reg <= RESP;
                        resp_reg  <= 1'b1;
                    end else begin
                        wait_cnt_reg <= wait_cnt_reg - 4'd1;
                    end
                end
                RESP: begin
                    state_reg <= IDLE;
                    if (req_reg.is_write) begin
                        wr_count_reg <= wr_count_reg + 16'd1;
                    end else begin
                        rd_count_reg <= rd_count_reg + 16'd1;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign resp_b   = resp_reg;
    assign rdata_b  = (resp_reg && req_reg.is_read) ? rd_data : 16'h0000;
    assign err      = err_reg;
    assign rd_count = rd_count_reg;
    assign wr_count = wr_count_reg;

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: directed vector table, hand-written
// abort/back-to-back/reset sequences and randomized traffic against a model.
module tb_dmem_responder;

    localparam int LAT   = 2;
    localparam int DEPTH = 256;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        read_b = 1'b0;
    logic        write_b = 1'b0;
    logic [1:0]  wmask_b = 2'b00;
    logic [15:0] address_b = 16'h0000;
    logic [15:0] wdata_b = 16'h0000;
    logic        resp_b;
    logic [15:0] rdata_b;
    logic        err;
    logic [15:0] rd_count;
    logic [15:0] wr_count;

    always #5 clk = ~clk;

    dmem_responder #(
        .LATENCY     (LAT),
        .DEPTH_WORDS (DEPTH)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .read_b    (read_b),
        .write_b   (write_b),
        .wmask_b   (wmask_b),
        .address_b (address_b),
        .wdata_b   (wdata_b),
        .resp_b    (resp_b),
        .rdata_b   (rdata_b),
        .err       (err),
        .rd_count  (rd_count),
        .wr_count  (wr_count)
    );

    int checks = 0;
    int errors = 0;

    // Behavioural model: word array plus counters and sticky error.
    logic [15:0] mem_m [DEPTH];
    int          rd_m;
    int          wr_m;
    bit          err_m;

    typedef struct {
        bit          rd;
        bit          wr;
        logic [1:0]  m;
        logic [15:0] a;
        logic [15:0] d;
        logic [15:0] exp_data;
        logic [15:0] exp_rd;
        logic [15:0] exp_wr;
        bit          exp_err;
    } vec_t;

    vec_t vecs [11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) mem_m[i] = 16'h0000;
        rd_m  = 0;
        wr_m  = 0;
        err_m = 0;
    endtask

    // Completed transaction: returns the data a reader should see.
    task automatic model_txn(input bit rd, input bit wr, input logic [1:0] m,
                             input logic [15:0] a, input logic [15:0] d,
                             output logic [15:0] exp_data);
        int idx;
        idx = (int'(a) / 2) % DEPTH;
        exp_data = rd ? mem_m[idx] : 16'h0000;
        if (wr) begin
            if (m[0]) mem_m[idx][7:0]  = d[7:0];
            if (m[1]) mem_m[idx][15:8] = d[15:8];
            wr_m = (wr_m + 1) % 65536;
            if (rd) err_m = 1;
        end else begin
            rd_m = (rd_m + 1) % 65536;
        end
    endtask

    // Hold the request from cycle T until resp, expect resp only at T+LAT.
    task automatic run_txn(input string name, input bit rd, input bit wr,
                           input logic [1:0] m, input logic [15:0] a,
                           input logic [15:0] d, input logic [15:0] exp_data);
        read_b = rd; write_b = wr; wmask_b = m; address_b = a; wdata_b = d;
        for (int c = 0; c <= LAT + 1; c++) begin
            if (c == LAT) begin
                check({name, " resp_b"}, 32'(resp_b), 32'd1);
                check({name, " rdata_b"}, 32'(rdata_b), 32'(exp_data));
                read_b = 1'b0;
                write_b = 1'b0;
            end else begin
                check($sformatf("%s resp_b c%0d", name, c), 32'(resp_b), 32'd0);
            end
            tick();
        end
        $display("txn %s rd=%0d wr=%0d m=%b a=%h d=%h rdata=%h rd_count=%0d wr_count=%0d err=%0d",
                 name, rd, wr, m, a, d, exp_data, rd_count, wr_count, err);
    endtask

    task automatic check_state(input string name);
        check({name, " rd_count"}, 32'(rd_count), 32'(rd_m));
        check({name, " wr_count"}, 32'(wr_count), 32'(wr_m));
        check({name, " err"}, 32'(err), 32'(err_m));
    endtask

    task automatic abort_txn(input string name, input bit rd, input bit wr,
                             input logic [15:0] a, input logic [15:0] d);
        read_b = rd; write_b = wr; wmask_b = 2'b11; address_b = a; wdata_b = d;
        tick();
        read_b = 1'b0;
        write_b = 1'b0;
        for (int c = 1; c <= LAT + 2; c++) begin
            check($sformatf("%s abort resp_b c%0d", name, c), 32'(resp_b), 32'd0);
            tick();
        end
        $display("abort %s rd=%0d wr=%0d a=%h", name, rd, wr, a);
    endtask

    initial begin
        logic [15:0] exp_d;
        logic [15:0] ra;
        logic [15:0] rd_val;
        int          op;
        bit          rr;
        bit          ww;

        vecs[0]  = '{1, 0, 2'b00, 16'h0010, 16'h0000, 16'h0000, 16'd1, 16'd0, 0};
        vecs[1]  = '{0, 1, 2'b11, 16'h0020, 16'hBEEF, 16'h0000, 16'd1, 16'd1, 0};
        vecs[2]  = '{1, 0, 2'b00, 16'h0020, 16'h0000, 16'hBEEF, 16'd2, 16'd1, 0};
        vecs[3]  = '{0, 1, 2'b10, 16'h0021, 16'h5500, 16'h0000, 16'd2, 16'd2, 0};
        vecs[4]  = '{1, 0, 2'b00, 16'h0020, 16'h0000, 16'h55EF, 16'd3, 16'd2, 0};
        vecs[5]  = '{0, 1, 2'b01, 16'h0220, 16'h1234, 16'h0000, 16'd3, 16'd3, 0};
        vecs[6]  = '{1, 0, 2'b00, 16'h0020, 16'h0000, 16'h5534, 16'd4, 16'd3, 0};
        vecs[7]  = '{0, 1, 2'b00, 16'h0020, 16'hFFFF, 16'h0000, 16'd4, 16'd4, 0};
        vecs[8]  = '{1, 0, 2'b00, 16'h0021, 16'h0000, 16'h5534, 16'd5, 16'd4, 0};
        vecs[9]  = '{1, 1, 2'b11, 16'h0020, 16'hA5A5, 16'h5534, 16'd5, 16'd5, 1};
        vecs[10] = '{1, 0, 2'b00, 16'h0020, 16'h0000, 16'hA5A5, 16'd6, 16'd5, 1};

        model_reset();
        for (int i = 0; i < 3; i++) tick();
        check("reset resp_b", 32'(resp_b), 32'd0);
        check("reset rdata_b", 32'(rdata_b), 32'd0);
        check_state("reset");

        // First request issued in the very first cycle out of reset.
        rst_n = 1'b1;
        for (int i = 0; i < 11; i++) begin
            run_txn($sformatf("vec%0d", i), vecs[i].rd, vecs[i].wr, vecs[i].m,
                    vecs[i].a, vecs[i].d, vecs[i].exp_data);
            model_txn(vecs[i].rd, vecs[i].wr, vecs[i].m, vecs[i].a, vecs[i].d, exp_d);
            check($sformatf("vec%0d rd_count", i), 32'(rd_count), 32'(vecs[i].exp_rd));
            check($sformatf("vec%0d wr_count", i), 32'(wr_count), 32'(vecs[i].exp_wr));
            check($sformatf("vec%0d err", i), 32'(err), 32'(vecs[i].exp_err));
        end

        // Aborted read and aborted write leave counts and storage untouched.
        abort_txn("abort_rd", 1, 0, 16'h0020, 16'h0000);
        check_state("abort_rd");
        abort_txn("abort_wr", 0, 1, 16'h0020, 16'h0000);
        check_state("abort_wr");
        model_txn(1, 0, 2'b00, 16'h0020, 16'h0000, exp_d);
        run_txn("after_abort", 1, 0, 2'b00, 16'h0020, 16'h0000, exp_d);
        check_state("after_abort");

        // Back-to-back: write A then read B accepted the cycle after A's resp.
        read_b = 1'b0; write_b = 1'b1; wmask_b = 2'b11;
        address_b = 16'h0044; wdata_b = 16'h1357;
        model_txn(0, 1, 2'b11, 16'h0044, 16'h1357, exp_d);
        model_txn(1, 0, 2'b00, 16'h0044, 16'h0000, rd_val);
        for (int c = 0; c <= 7; c++) begin
            check($sformatf("b2b resp_b c%0d", c), 32'(resp_b),
                  32'((c == LAT) || (c == 2 * LAT + 1)));
            if (c == LAT) begin
                check("b2b A rdata_b", 32'(rdata_b), 32'h0000);
                write_b = 1'b0;
                read_b  = 1'b1;
            end
            if (c == 2 * LAT + 1) begin
                check("b2b B rdata_b", 32'(rdata_b), 32'(rd_val));
                read_b = 1'b0;
            end
            tick();
        end
        $display("b2b write 0044=1357 then read rdata=%h", rd_val);
        check_state("b2b");

        // Randomized traffic with aliasing addresses.
        for (int n = 0; n < 60; n++) begin
            op = int'($urandom_range(0, 9));
            ra = 16'($urandom_range(0, 63));
            if ($urandom_range(0, 3) == 0) ra = ra | (16'h0200 << $urandom_range(0, 6));
            if (op == 9) begin
                abort_txn($sformatf("rnd%0d", n), 1'($urandom_range(0, 1)), 1'b1, ra, 16'($urandom));
            end else begin
                rr = (op <= 3) || (op == 8);
                ww = (op >= 4);
                wmask_b = 2'($urandom_range(0, 3));
                wdata_b = 16'($urandom);
                model_txn(rr, ww, wmask_b, ra, wdata_b, exp_d);
                run_txn($sformatf("rnd%0d", n), rr, ww, wmask_b, ra, wdata_b, exp_d);
            end
            check_state($sformatf("rnd%0d", n));
        end

        // Reset while a write sits in WAIT: nothing completes, all cleared.
        read_b = 1'b0; write_b = 1'b1; wmask_b = 2'b11;
        address_b = 16'h0030; wdata_b = 16'h1111;
        tick();
        check("rst_wait resp_b", 32'(resp_b), 32'd0);
        rst_n = 1'b0;
        write_b = 1'b0;
        tick();
        rst_n = 1'b1;
        model_reset();
        for (int c = 0; c < 3; c++) begin
            check($sformatf("rst_wait resp_b c%0d", c), 32'(resp_b), 32'd0);
            tick();
        end
        check_state("rst_wait");
        $display("reset during WAIT applied");
        model_txn(1, 0, 2'b00, 16'h0030, 16'h0000, exp_d);
        run_txn("post_rst_0030", 1, 0, 2'b00, 16'h0030, 16'h0000, exp_d);
        model_txn(1, 0, 2'b00, 16'h0020, 16'h0000, exp_d);
        run_txn("post_rst_0020", 1, 0, 2'b00, 16'h0020, 16'h0000, exp_d);
        model_txn(1, 0, 2'b00, 16'h0044, 16'h0000, exp_d);
        run_txn("post_rst_0044", 1, 0, 2'b00, 16'h0044, 16'h0000, exp_d);
        check_state("post_rst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 The module SHALL have parameter LATENCY, default 2, meaning cycles from request sample to resp_b (legal range 1..15).
REQ-002 The module SHALL have parameter DEPTH_WORDS, default 256, meaning storage depth in 16-bit words (power of two).
REQ-003 The module SHALL use a single clock and a synchronous, active-low reset.
REQ-004 Port: clk  input  1  clock; all state updates on rising edge.
REQ-005 Port: rst_n  input  1  synchronous active-low reset.
REQ-006 Port: read_b  input  1  read request, held by the initiator until resp_b.
REQ-007 Port: write_b  input  1  write request, held by the initiator until resp_b.
REQ-008 Port: wmask_b  input  2  byte enables; bit0 selects [7:0], bit1 selects [15:8].
REQ-009 Port: address_b  input  16  byte address; bit 0 is ignored for word select.
REQ-010 Port: wdata_b  input  16  write data.
REQ-011 Port: resp_b  output  1  one-cycle completion pulse.
REQ-012 Port: rdata_b  output  16  read data, valid only while resp_b=1.
REQ-013 Port: err  output  1  sticky protocol-error flag.
REQ-014 Port: rd_count  output  16  count of completed reads.
REQ-015 Port: wr_count  output  16  count of completed writes.

Function
REQ-016 The FSM SHALL have exactly three states: IDLE, WAIT and RESP.
REQ-017 In IDLE, a sampled read_b|write_b SHALL latch address, wdata, mask and operation, then enter WAIT, or enter RESP directly if LATENCY=1.
REQ-018 For a request first sampled high in cycle T, resp_b SHALL be 1 in cycle T+LATENCY only, and 0 in all other cycles.
REQ-019 In WAIT, if read_b|write_b is sampled low, the transaction SHALL abort: go to IDLE, no resp_b, no write, no count.
REQ-020 Requests SHALL NOT be sampled in WAIT or RESP; RESP SHALL always return to IDLE.
REQ-021 A new request SHALL be accepted in the cycle directly after RESP (back-to-back).
REQ-022 Word index SHALL be address_b[15:1] modulo DEPTH_WORDS.
REQ-023 A read SHALL drive rdata_b with the latched word during RESP, and 16'h0000 otherwise.
REQ-024 A write SHALL update only the mask-enabled bytes, on the clock edge ending the RESP cycle.
REQ-025 A write with wmask_b=00 SHALL still complete with resp_b and increment wr_count, without changing storage.
REQ-026 If read_b and write_b are both sampled high in IDLE, the transaction SHALL be a write, rdata_b SHALL return the pre-write word, and err SHALL be set.
REQ-027 rd_count and wr_count SHALL increment on the edge ending RESP, wrapping from 16'hFFFF to 0.

Reset
REQ-028 When rst_n=0 at a rising edge, the block SHALL go to IDLE with resp_b=0, err=0 and both counts at 0.
REQ-029 When rst_n=0 at a rising edge, the block SHALL zero all storage and discard any pending transaction, including one in WAIT or RESP.
REQ-030 The first request SHALL be sampled in the first cycle with rst_n=1.

Structure
REQ-031 lc3b_types SHALL define the state enum lc3b_dmem_state, and the block SHALL reuse lc3b_word.
REQ-032 Storage with byte-masked write SHALL be the single sub-module dmem_array; the FSM, latency counter and counters SHALL be in dmem_responder.

Verification
REQ-033 Reset, then read 0x0010 held from cycle T -> resp_b=1 in T+2 only, rdata_b=0x0000, rd_count=1.
REQ-034 Write 0x0020, wdata 0xBEEF, mask 11, then read 0x0020 -> rdata_b=0xBEEF at its resp, wr_count=1.
REQ-035 Write 0x0021, wdata 0x5500, mask 10 over 0xBEEF, then read 0x0020 -> 0x55EF.
REQ-036 Read asserted 1 cycle then dropped -> no resp_b, counts unchanged, FSM in IDLE; next read completes normally.
REQ-037 Back-to-back: request B asserted the cycle after A's resp -> B's resp exactly 2 cycles later; read_b and write_b both high -> write performed, err=1 until reset.
REQ-038 rst_n=0 during WAIT of a write -> no resp_b, storage reads 0x0000, counts 0, err 0.
